// File: rtl/scram_mp_pkg.sv
// Shared definitions for the multi-port scratchpad.
//   portw()   : index width for a given port count (at least 1 bit)
//   rd_tag_t  : control half of a read-pipeline stage (valid + port tag).
//               The data half travels alongside it at the instance's DATAW.
package scram_mp_pkg;

  // Widest supported port count and the tag width that covers it.
  localparam int MAX_PORTS = 8;
  localparam int TAGW      = 3;

  function automatic int portw(input int nports);
    return (nports > 1) ? $clog2(nports) : 1;
  endfunction

  typedef struct packed {
    logic            valid;
    logic [TAGW-1:0] tag;
  } rd_tag_t;

endpackage

// File: rtl/scram_mp_if.sv
// Request/response bundle between NPORTS requesters and the scratchpad.
//   master : drives en/wr/addr/wdata/strb, receives ready/rvalid/rdata
//   slave  : the scratchpad side
// Port i occupies slice [i*W +: W] of every packed vector.
interface scram_mp_if #(
  parameter int NPORTS = 3,
  parameter int ADDRW  = 8,
  parameter int DATAW  = 32
);
  logic [NPORTS-1:0]         en;
  logic [NPORTS-1:0]         wr;
  logic [NPORTS*ADDRW-1:0]   addr;
  logic [NPORTS*DATAW-1:0]   wdata;
  logic [NPORTS*DATAW/8-1:0] strb;
  logic [NPORTS-1:0]         ready;
  logic [NPORTS-1:0]         rvalid;
  logic [NPORTS*DATAW-1:0]   rdata;

  modport master (output en, wr, addr, wdata, strb,
                  input  ready, rvalid, rdata);
  modport slave  (input  en, wr, addr, wdata, strb,
                  output ready, rvalid, rdata);
endinterface

// File: rtl/scram_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle among the requesting ports.
//   aclk, srst : clock, synchronous active-high reset
//   en         : per-port request
//   grant      : one-hot grant (combinational, zero while srst is high)
//   grant_idx  : index of the granted port
//   grant_any  : a grant was issued this cycle
module scram_rr_arbiter
  import scram_mp_pkg::*;
#(
  parameter int NPORTS = 3,
  parameter int PORTW  = portw(NPORTS)
) (
  input  logic              aclk,
  input  logic              srst,
  input  logic [NPORTS-1:0] en,
  output logic [NPORTS-1:0] grant,
  output logic [PORTW-1:0]  grant_idx,
  output logic              grant_any
);

  logic [PORTW-1:0] last_grant_reg;

  // Search begins one past the previous winner; the first requester found wins.
  always_comb begin
    int               cand;
    logic [PORTW-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 1; k <= NPORTS; k++) begin
      cand     = (int'(last_grant_reg) + k) % NPORTS;
      cand_idx = PORTW'(cand);
      if (!srst && !grant_any && en[cand_idx]) begin
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
        grant_any       = 1'b1;
      end
    end
  end

  // Reset to the last port so port 0 has first priority.
  always_ff @(posedge aclk) begin
    if (srst) begin
      last_grant_reg <= PORTW'(NPORTS - 1);
    end else if (grant_any) begin
      last_grant_reg <= grant_idx;
    end
  end

endmodule

// File: rtl/scram_mp.sv
// Multi-port scratchpad: NPORTS requesters share one single-ported array.
//   aclk, srst : clock, synchronous active-high reset
//   bus        : scram_mp_if slave (en/wr/addr/wdata/strb in,
//                ready/rvalid/rdata out, one slice per port)
// A read granted in cycle t returns rvalid/rdata in cycle t+RD_LAT.
module scram_mp
  import scram_mp_pkg::*;
#(
  parameter int NPORTS = 3,
  parameter int ADDRW  = 8,
  parameter int DATAW  = 32,
  parameter int RD_LAT = 1
) (
  input logic       aclk,
  input logic       srst,
  scram_mp_if.slave bus
);

  localparam int PORTW  = portw(NPORTS);
  localparam int NBYTES = DATAW / 8;
  localparam int DEPTH  = 1 << ADDRW;

  logic [NPORTS-1:0] grant;
  logic [PORTW-1:0]  grant_idx;
  logic              grant_any;

  scram_rr_arbiter #(.NPORTS(NPORTS), .PORTW(PORTW)) u_arb (
    .aclk      (aclk),
    .srst      (srst),
    .en        (bus.en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign bus.ready = grant;

  // Steer the granted port's request onto the array.
  logic              sel_wr;
  logic [ADDRW-1:0]  sel_addr;
  logic [DATAW-1:0]  sel_wdata;
  logic [NBYTES-1:0] sel_strb;

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_strb  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (grant[p]) begin
        sel_wr    = bus.wr[p];
        sel_addr  = bus.addr[p*ADDRW +: ADDRW];
        sel_wdata = bus.wdata[p*DATAW +: DATAW];
        sel_strb  = bus.strb[p*NBYTES +: NBYTES];
      end
    end
  end

  logic do_wr;
  logic do_rd;
  assign do_wr = grant_any & sel_wr;
  assign do_rd = grant_any & ~sel_wr;

  // Storage with byte-enable write and registered read (first latency stage).
  logic [DATAW-1:0] mem [DEPTH];
  logic [DATAW-1:0] ram_q;

  always_ff @(posedge aclk) begin
    if (do_wr) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (sel_strb[b]) begin
          mem[sel_addr][b*8 +: 8] <= sel_wdata[b*8 +: 8];
        end
      end
    end
    if (do_rd) begin
      ram_q <= mem[sel_addr];
    end
  end

  // Tag pipeline: stage 0 is loaded on the grant edge, in step with ram_q.
  rd_tag_t hdr_reg [RD_LAT];

  always_ff @(posedge aclk) begin
    if (srst) begin
      for (int k = 0; k < RD_LAT; k++) begin
        hdr_reg[k] <= '0;
      end
    end else begin
      hdr_reg[0] <= '{valid: do_rd, tag: TAGW'(grant_idx)};
      for (int k = 1; k < RD_LAT; k++) begin
        hdr_reg[k] <= hdr_reg[k-1];
      end
    end
  end

  // Data follows the tags through the remaining RD_LAT-1 stages.
  logic [DATAW-1:0] exit_data;

  if (RD_LAT == 1) begin : g_lat1
    assign exit_data = ram_q;
  end else begin : g_latn
    logic [DATAW-1:0] dly_reg [RD_LAT-1];
    always_ff @(posedge aclk) begin
      dly_reg[0] <= ram_q;
      for (int k = 1; k < RD_LAT - 1; k++) begin
        dly_reg[k] <= dly_reg[k-1];
      end
    end
    assign exit_data = dly_reg[RD_LAT-2];
  end

  rd_tag_t exit_hdr;
  assign exit_hdr = hdr_reg[RD_LAT-1];

  // Per-port return: rdata shows the exiting word during the rvalid cycle
  // and the held copy otherwise.
  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
    logic             hit;
    logic [DATAW-1:0] hold_reg;

    assign hit = exit_hdr.valid && (exit_hdr.tag == TAGW'(gi));

    always_ff @(posedge aclk) begin
      if (srst) begin
        hold_reg <= '0;
      end else if (hit) begin
        hold_reg <= exit_data;
      end
    end

    assign bus.rvalid[gi]              = hit;
    assign bus.rdata[gi*DATAW +: DATAW] = hit ? exit_data : hold_reg;
  end

endmodule
